// File: rtl/enc_inverse_decoder.sv
// rtl/enc_inverse_decoder.sv - exhaustive-scan inverse lookup of a small combinational encoder
module enc_inverse_decoder #(
    parameter int IN_W        = 4,
    parameter int OUT_W       = 3,
    parameter int FIRST_MATCH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  enc_i,
    input  logic [OUT_W-1:0] enc_o,
    output logic             busy,
    output logic             done,
    input  logic             q_valid,
    input  logic [OUT_W-1:0] q_code,
    output logic             q_ready,
    output logic             r_valid,
    output logic             r_found,
    output logic [IN_W-1:0]  r_value,
    output logic [IN_W:0]    r_count,
    input  logic             r_ready
);

    localparam int DEPTH = 1 << OUT_W;
    localparam logic [IN_W-1:0] LAST_IN = '1;

    typedef enum logic [1:0] {IDLE, SCAN, SERVE} state_t;

    state_t state, state_nx;

    logic [IN_W:0]   cnt [DEPTH];
    logic [IN_W-1:0] val [DEPTH];

    logic restart;
    logic scan_end;
    logic accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        scan_end = 1'b0;
        busy     = 1'b0;
        q_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    restart  = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (enc_i == LAST_IN) begin
                    scan_end = 1'b1;
                    state_nx = SERVE;
                end
            end
            SERVE: begin
                // Refuse new queries in the cycle a rescan is requested.
                q_ready = !start && (!r_valid || r_ready);
                if (start) begin
                    restart  = 1'b1;
                    state_nx = SCAN;
                end
            end
            default: state_nx = IDLE;
        endcase
        accept = q_valid && q_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_i   <= '0;
            done    <= 1'b0;
            r_valid <= 1'b0;
            r_found <= 1'b0;
            r_value <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= '0;
                val[i] <= '0;
            end
        end else begin
            done <= scan_end;
            if (restart) begin
                enc_i   <= '0;
                r_valid <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    cnt[i] <= '0;
                    val[i] <= '0;
                end
            end else if (state == SCAN) begin
                // enc_i wraps to 0 after the last code and holds there in SERVE.
                enc_i      <= enc_i + 1'b1;
                cnt[enc_o] <= cnt[enc_o] + 1'b1;
                if (cnt[enc_o] == '0 || FIRST_MATCH == 0) begin
                    val[enc_o] <= enc_i;
                end
            end else if (state == SERVE) begin
                if (accept) begin
                    r_valid <= 1'b1;
                    r_count <= cnt[q_code];
                    r_found <= (cnt[q_code] != '0);
                    r_value <= val[q_code];
                end else if (r_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_enc_inverse_decoder.sv
// tb/tb_enc_inverse_decoder.sv - randomized self-checking bench for enc_inverse_decoder
module tb_enc_inverse_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, q_valid, r_ready;
    logic [2:0] q_code;
    logic [3:0] enc_i_f, enc_i_l;
    logic [2:0] enc_o_f, enc_o_l;
    logic       busy_f, busy_l, done_f, done_l, q_ready_f, q_ready_l;
    logic       r_valid_f, r_valid_l, r_found_f, r_found_l;
    logic [3:0] r_value_f, r_value_l;
    logic [4:0] r_count_f, r_count_l;
    logic [10:0] obs_f, obs_l;

    // The attached encoder: a lookup table the bench can reprogram.
    logic [2:0] enc_map [16];
    assign enc_o_f = enc_map[enc_i_f];
    assign enc_o_l = enc_map[enc_i_l];
    assign obs_f = {r_valid_f, r_found_f, r_value_f, r_count_f};
    assign obs_l = {r_valid_l, r_found_l, r_value_l, r_count_l};

    int vectors = 0;
    int miscompares = 0;

    enc_inverse_decoder #(.IN_W(4), .OUT_W(3), .FIRST_MATCH(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .start(start), .enc_i(enc_i_f), .enc_o(enc_o_f),
        .busy(busy_f), .done(done_f), .q_valid(q_valid), .q_code(q_code),
        .q_ready(q_ready_f), .r_valid(r_valid_f), .r_found(r_found_f),
        .r_value(r_value_f), .r_count(r_count_f), .r_ready(r_ready)
    );

    enc_inverse_decoder #(.IN_W(4), .OUT_W(3), .FIRST_MATCH(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start), .enc_i(enc_i_l), .enc_o(enc_o_l),
        .busy(busy_l), .done(done_l), .q_valid(q_valid), .q_code(q_code),
        .q_ready(q_ready_l), .r_valid(r_valid_l), .r_found(r_found_l),
        .r_value(r_value_l), .r_count(r_count_l), .r_ready(r_ready)
    );

    // Reference: enumerate every input and pick the smallest or largest preimage.
    function automatic logic [10:0] expect_resp(input logic [2:0] code, input bit use_last);
        logic       found;
        logic [3:0] value;
        logic [4:0] count;
        found = 1'b0;
        value = '0;
        count = '0;
        for (int i = 0; i < 16; i++) begin
            if (enc_map[i] == code) begin
                if (!found || use_last) value = i[3:0];
                found = 1'b1;
                count = count + 5'd1;
            end
        end
        return {1'b1, found, value, count};
    endfunction

    task automatic load_ex2();
        enc_map = '{3'd6, 3'd5, 3'd6, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1,
                    3'd6, 3'd5, 3'd2, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
    endtask

    task automatic do_query(input logic [2:0] code, input int hold,
                            output logic [10:0] got_f, output logic [10:0] got_l);
        int n;
        n = 0;
        q_valid = 1'b1;
        q_code  = code;
        @(negedge clk);
        while (!q_ready_f && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL query_accept: q_ready=%0b after %0d cycles, want 1", q_ready_f, n);
        end
        @(posedge clk); #1;
        q_valid = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        got_f = obs_f;
        got_l = obs_l;
        @(posedge clk); #1;
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    task automatic run_scan();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            vectors++;
            if ({enc_i_f, enc_i_l, busy_f, busy_l, q_ready_f, done_f} !== {k[3:0], k[3:0], 4'b1100}) begin
                miscompares++;
                $display("FAIL scan_cycle%0d: enc_i=%0d busy=%0b q_ready=%0b done=%0b, want enc_i=%0d busy=1 q_ready=0 done=0",
                         k, enc_i_f, busy_f, q_ready_f, done_f, k);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        vectors++;
        if ({done_f, done_l, busy_f, enc_i_f} !== {3'b110, 4'd0}) begin
            miscompares++;
            $display("FAIL scan_done: done=%0b busy=%0b enc_i=%0d, want done=1 busy=0 enc_i=0", done_f, busy_f, enc_i_f);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({done_f, done_l, busy_f, enc_i_f} !== 7'd0) begin
            miscompares++;
            $display("FAIL scan_after: done=%0b busy=%0b enc_i=%0d, want all 0", done_f, busy_f, enc_i_f);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; q_valid = 1'b0; q_code = '0; r_ready = 1'b0;
        load_ex2();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if ({enc_i_f, busy_f, done_f, q_ready_f, obs_f, enc_i_l, busy_l, done_l, q_ready_l, obs_l} !== '0) begin
            miscompares++;
            $display("FAIL reset: f=%h/%b%b%b/%h l=%h/%b%b%b/%h, want all 0", enc_i_f, busy_f, done_f, q_ready_f,
                     obs_f, enc_i_l, busy_l, done_l, q_ready_l, obs_l);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_ex2_table();
        int fd [8] = '{1, 1, 1, 0, 0, 1, 1, 0};
        int vf [8] = '{12, 3, 4, 0, 0, 1, 0, 0};
        int vl [8] = '{14, 15, 10, 0, 0, 9, 8, 0};
        int cn [8] = '{2, 6, 3, 0, 0, 2, 3, 0};
        logic [10:0] got_f, got_l, want_f, want_l;
        for (int c = 0; c < 8; c++) begin
            do_query(c[2:0], 0, got_f, got_l);
            want_f = {1'b1, 1'(fd[c]), 4'(vf[c]), 5'(cn[c])};
            want_l = {1'b1, 1'(fd[c]), 4'(vl[c]), 5'(cn[c])};
            vectors++;
            if (got_f !== want_f || got_l !== want_l) begin
                miscompares++;
                $display("FAIL ex2_code%0d: first=%h last=%h, want first=%h last=%h", c, got_f, got_l, want_f, want_l);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [3] = '{3'd6, 3'd1, 3'd5};
        logic [10:0] held_f, held_l;
        @(posedge clk); #1;
        r_ready = 1'b1; q_valid = 1'b1; q_code = codes[0];
        @(negedge clk);
        vectors++;
        if (q_ready_f !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: q_ready=%0b, want 1", q_ready_f);
        end
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            if (j < 2) begin
                q_code = codes[j+1];
            end else begin
                r_ready = 1'b0;
                q_code  = 3'd2;
            end
            @(negedge clk);
            vectors++;
            if (obs_f !== expect_resp(codes[j], 0) || obs_l !== expect_resp(codes[j], 1)) begin
                miscompares++;
                $display("FAIL b2b_resp%0d: first=%h last=%h, want %h %h", j, obs_f, obs_l,
                         expect_resp(codes[j], 0), expect_resp(codes[j], 1));
            end
        end
        held_f = expect_resp(3'd5, 0);
        held_l = expect_resp(3'd5, 1);
        for (int h = 0; h < 3; h++) begin
            if (h > 0) @(negedge clk);
            vectors++;
            if (q_ready_f !== 1'b0 || obs_f !== held_f || obs_l !== held_l) begin
                miscompares++;
                $display("FAIL b2b_hold%0d: q_ready=%0b first=%h last=%h, want 0 %h %h", h, q_ready_f, obs_f, obs_l,
                         held_f, held_l);
            end
            @(posedge clk); #1;
        end
        r_ready = 1'b1;
        @(posedge clk); #1;
        q_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs_f !== expect_resp(3'd2, 0) || obs_l !== expect_resp(3'd2, 1)) begin
            miscompares++;
            $display("FAIL b2b_release: first=%h last=%h, want %h %h", obs_f, obs_l,
                     expect_resp(3'd2, 0), expect_resp(3'd2, 1));
        end
        @(posedge clk); #1;
        r_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (r_valid_f !== 1'b0 || r_valid_l !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: r_valid=%0b/%0b, want 0", r_valid_f, r_valid_l);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        logic [10:0] got_f, got_l;
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({enc_i_f, busy_f, done_f, q_ready_f, obs_f, enc_i_l, busy_l, done_l, q_ready_l, obs_l} !== '0) begin
            miscompares++;
            $display("FAIL midscan_reset: enc_i=%0d busy=%0b done=%0b q_ready=%0b resp=%h, want all 0",
                     enc_i_f, busy_f, done_f, q_ready_f, obs_f);
        end
        repeat (20) begin
            @(negedge clk);
            if (done_f || done_l || busy_f || busy_l) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL midscan_idle: busy/done high in %0d cycles, want 0", seen);
        end
        @(posedge clk); #1;
        run_scan();
        for (int c = 0; c < 8; c++) begin
            do_query(c[2:0], 0, got_f, got_l);
            vectors++;
            if (got_f !== expect_resp(c[2:0], 0) || got_l !== expect_resp(c[2:0], 1)) begin
                miscompares++;
                $display("FAIL midscan_table%0d: first=%h last=%h, want %h %h", c, got_f, got_l,
                         expect_resp(c[2:0], 0), expect_resp(c[2:0], 1));
            end
        end
    endtask

    task automatic test_start_in_serve();
        int n;
        logic [10:0] got_f, got_l;
        n = 0;
        @(posedge clk); #1;
        q_valid = 1'b1; q_code = 3'd1;
        @(posedge clk); #1;
        start = 1'b1; q_code = 3'd3;
        @(negedge clk);
        vectors++;
        if (r_valid_f !== 1'b1 || q_ready_f !== 1'b0 || q_ready_l !== 1'b0) begin
            miscompares++;
            $display("FAIL serve_start_ready: r_valid=%0b q_ready=%0b, want 1 0", r_valid_f, q_ready_f);
        end
        @(posedge clk); #1;
        start = 1'b0; q_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (r_valid_f !== 1'b0 || r_valid_l !== 1'b0 || busy_f !== 1'b1) begin
            miscompares++;
            $display("FAIL serve_start_drop: r_valid=%0b busy=%0b, want 0 1", r_valid_f, busy_f);
        end
        while (!done_f && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 40) begin
            miscompares++;
            $display("FAIL serve_rescan_done: no done within %0d cycles", n);
        end
        @(posedge clk); #1;
        do_query(3'd1, 1, got_f, got_l);
        vectors++;
        if (got_f !== {2'b11, 4'd3, 5'd6} || got_l !== {2'b11, 4'd15, 5'd6}) begin
            miscompares++;
            $display("FAIL serve_rescan_q1: first=%h last=%h, want %h %h", got_f, got_l,
                     {2'b11, 4'd3, 5'd6}, {2'b11, 4'd15, 5'd6});
        end
    endtask

    task automatic test_random_encoders();
        logic [2:0]  code, same;
        logic [10:0] got_f, got_l;
        for (int t = 0; t < 4; t++) begin
            same = 3'($urandom_range(0, 7));
            for (int i = 0; i < 16; i++) begin
                enc_map[i] = (t == 0) ? same : 3'($urandom_range(0, 7));
            end
            run_scan();
            for (int q = 0; q < 10; q++) begin
                code = (t == 0 && q == 0) ? same : 3'($urandom_range(0, 7));
                do_query(code, int'($urandom_range(0, 2)), got_f, got_l);
                vectors++;
                if (got_f !== expect_resp(code, 0) || got_l !== expect_resp(code, 1)) begin
                    miscompares++;
                    $display("FAIL rand_t%0d_q%0d code=%0d: first=%h last=%h, want %h %h", t, q, code,
                             got_f, got_l, expect_resp(code, 0), expect_resp(code, 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        run_scan();
        test_ex2_table();
        test_back_to_back();
        test_reset_mid_scan();
        test_start_in_serve();
        test_random_encoders();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
